// File: rtl/config_loader.sv
// config_loader: streams host configuration words into a logic-slice shift chain, with optional readback verify.
// Ports:
//   clk, res           rising-edge clock, asynchronous active-high reset
//   start, verify      begin a load (sampled in IDLE); verify=1 means the host sends the bitstream twice
//   abort              terminate any load and return to IDLE
//   cfg_data/valid     host word stream; cfg_ready is high while loading
//   prog_o, prog_shft  word and shift enable driven into the chain
//   prog_ret           chain last-stage output, compared against prog_o during the verify pass
//   busy, done, err    status: loading, one-cycle completion pulse, sticky readback mismatch
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 83
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [WORD_W-1:0] prog_o,
    output logic              prog_shft,
    input  logic [WORD_W-1:0] prog_ret,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wcnt_q, wcnt_d;
    logic [WORD_W-1:0] prog_o_q, prog_o_d;
    logic              vflag_q, vflag_d;
    logic              shft_q, shft_d;
    logic              cmp_q, cmp_d;
    logic              fin_q, fin_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rdy_q;
    logic              hs, at_last, start_ok, mism, to_verify;

    assign cfg_ready = state_q != IDLE;
    assign hs        = cfg_valid & cfg_ready;
    assign at_last   = wcnt_q == LAST;
    // rdy_q blocks a start on the first edge after reset release; busy_q covers
    // the trailing shift cycle so a start never overlaps done or a final compare
    assign start_ok  = start & rdy_q & ~busy_q;
    // cmp_q marks that the word now on prog_o belongs to the readback pass
    assign mism      = shft_q & cmp_q & (prog_ret != prog_o_q);
    assign to_verify = (state_q == LOAD) & vflag_q;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        vflag_d  = vflag_q;
        prog_o_d = prog_o_q;
        shft_d   = 1'b0;
        cmp_d    = 1'b0;
        fin_d    = 1'b0;
        done_d   = fin_q & ~abort;
        err_d    = err_q | mism;
        if (abort) begin
            state_d = IDLE;
            wcnt_d  = '0;
        end else if (state_q == IDLE) begin
            if (start_ok) begin
                state_d = LOAD;
                wcnt_d  = '0;
                vflag_d = verify;
                err_d   = 1'b0;
            end
        end else if (hs) begin
            prog_o_d = cfg_data;
            shft_d   = 1'b1;
            cmp_d    = state_q == VERIFY;
            wcnt_d   = at_last ? '0 : wcnt_q + 1'b1;
            if (at_last) begin
                state_d = to_verify ? VERIFY : IDLE;
                fin_d   = ~to_verify;
            end
        end
        busy_d = (state_d != IDLE) | shft_d;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            vflag_q  <= 1'b0;
            prog_o_q <= '0;
            shft_q   <= 1'b0;
            cmp_q    <= 1'b0;
            fin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            vflag_q  <= vflag_d;
            prog_o_q <= prog_o_d;
            shft_q   <= shft_d;
            cmp_q    <= cmp_d;
            fin_q    <= fin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_q    <= 1'b1;
        end
    end

    assign prog_o    = prog_o_q;
    assign prog_shft = shft_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
